// File: rtl/fp16_div_pkg.sv
// Shared fp16 constants, divider FSM states and leading-zero counter.
// Latency: n/a (declarations and a combinational helper only).
// Backpressure: n/a.
package fp16_div_pkg;

   localparam int          FP16_BIAS    = 15;
   localparam logic [15:0] FP16_QNAN    = 16'h7E00;
   localparam logic [15:0] FP16_ZERO    = 16'h0000;
   localparam logic [4:0]  FP16_INF_EXP = 5'h1F;

   // 14 quotient bits: the counter starts at 13 and exits DIV on 0
   localparam logic [3:0]  DIV_LAST_IDX = 4'd13;

   typedef enum logic [1:0] {IDLE, DIV, ROUND, DONE} state_t;

   // Leading zeros of an 11-bit significand (11 when all zero)
   function automatic logic [3:0] lzc11(input logic [10:0] v);
      lzc11 = 4'd11;
      for (int i = 0; i < 11; i++) begin
         if (v[i]) lzc11 = 4'(10 - i);
      end
   endfunction

endpackage

// File: rtl/fp16_round_pack.sv
// Packs sign, signed exponent and 14-bit quotient into fp16 with RNE rounding.
// Latency: combinational.
// Backpressure: none (pure function of its inputs).
module fp16_round_pack
   import fp16_div_pkg::*;
(
   input  logic              sign,
   input  logic signed [7:0] exp,
   input  logic [13:0]       sig,
   input  logic              sticky,
   output logic [15:0]       result
);

   logic              denorm;
   logic signed [7:0] diff;
   logic [3:0]        sh;
   logic [27:0]       wide;
   logic [13:0]       shifted;
   logic              guard;
   logic              st;
   logic              inc;
   logic [11:0]       sum;
   logic signed [7:0] exp_out;

   // Denormal right shift, round-to-nearest-even, carry into exponent, overflow to inf
   always_comb begin
      denorm  = (exp <= 8'sd0);
      diff    = 8'sd1 - exp;
      sh      = 4'd0;
      if (denorm) sh = (diff > 8'sd13) ? 4'd13 : diff[3:0];
      wide    = {sig, 14'b0} >> sh;
      shifted = wide[27:14];
      guard   = shifted[2];
      st      = sticky | (|shifted[1:0]) | (|wide[13:0]);
      inc     = guard & (st | shifted[3]);
      sum     = {1'b0, shifted[13:3]} + {11'b0, inc};
      // a denormal that rounds up into the hidden bit becomes exponent 1
      if (denorm) exp_out = {7'b0, sum[10]};
      else        exp_out = sum[11] ? exp + 8'sd1 : exp;
      if (exp_out >= 8'sd31) result = {sign, FP16_INF_EXP, 10'b0};
      else                   result = {sign, exp_out[4:0], sum[9:0]};
   end

endmodule

// File: rtl/fp16_div.sv
// Iterative fp16 divider, restoring radix-2, one quotient bit per cycle, RNE.
// Latency: out_valid 16 cycles after accept (1 cycle for special operands).
// Backpressure: one op in flight; result held in DONE until out_ready, in_ready only in IDLE.
module fp16_div
   import fp16_div_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] a,
   input  logic [15:0] b,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] result
);

   state_t            state, state_nxt;
   logic [3:0]        cnt;
   logic [11:0]       rem;
   logic [13:0]       q;
   logic [10:0]       mb;
   logic signed [7:0] eq;
   logic              sign;

   // unpack / special detection
   logic [10:0]       siga, sigb, ma_n, mb_n;
   logic [3:0]        lza, lzb;
   logic signed [6:0] ea_eff, eb_eff;
   logic signed [7:0] eq_calc;
   logic              a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, sq;
   logic              spec_hit;
   logic [15:0]       spec_val;

   // round stage
   logic [13:0]       q_n;
   logic signed [7:0] e_n;
   logic              stk;
   logic [11:0]       rem_sub;
   logic [15:0]       packed_res;

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);

   // Unpack operands: pre-normalise denormals, derive quotient exponent and special results
   always_comb begin
      siga    = {|a[14:10], a[9:0]};
      sigb    = {|b[14:10], b[9:0]};
      lza     = lzc11(siga);
      lzb     = lzc11(sigb);
      ma_n    = siga << lza;
      mb_n    = sigb << lzb;
      ea_eff  = ((a[14:10] == 5'd0) ? 7'sd1 : $signed({2'b00, a[14:10]})) - $signed({3'b000, lza});
      eb_eff  = ((b[14:10] == 5'd0) ? 7'sd1 : $signed({2'b00, b[14:10]})) - $signed({3'b000, lzb});
      eq_calc = {ea_eff[6], ea_eff} - {eb_eff[6], eb_eff} + 8'(FP16_BIAS);
      sq      = a[15] ^ b[15];
      a_nan   = (a[14:10] == FP16_INF_EXP) && (a[9:0] != 10'd0);
      b_nan   = (b[14:10] == FP16_INF_EXP) && (b[9:0] != 10'd0);
      a_inf   = (a[14:10] == FP16_INF_EXP) && (a[9:0] == 10'd0);
      b_inf   = (b[14:10] == FP16_INF_EXP) && (b[9:0] == 10'd0);
      a_zero  = (a[14:0] == 15'd0);
      b_zero  = (b[14:0] == 15'd0);
      spec_hit = 1'b1;
      spec_val = FP16_QNAN;
      if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) spec_val = FP16_QNAN;
      else if (a_inf)              spec_val = {sq, FP16_INF_EXP, 10'b0};
      else if (b_zero)             spec_val = {sq, FP16_INF_EXP, 10'b0};
      else if (a_zero || b_inf)    spec_val = {sq, FP16_ZERO[14:0]};
      else                         spec_hit = 1'b0;
   end

   // Normalise the raw quotient and gather sticky from round bits and remainder
   always_comb begin
      q_n     = q[13] ? q  : {q[12:0], 1'b0};
      e_n     = q[13] ? eq : eq - 8'sd1;
      stk     = (|q_n[1:0]) | (rem != 12'd0);
      rem_sub = rem - {1'b0, mb};
   end

   fp16_round_pack u_round_pack (
      .sign   (sign),
      .exp    (e_n),
      .sig    (q_n),
      .sticky (stk),
      .result (packed_res)
   );

   // Next-state decode
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (in_valid) state_nxt = spec_hit ? DONE : DIV;
         DIV:     if (cnt == 4'd0) state_nxt = ROUND;
         ROUND:   state_nxt = DONE;
         DONE:    if (out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // State register and datapath: capture on accept, one restoring step per DIV cycle, register result
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         cnt    <= 4'd0;
         rem    <= 12'd0;
         q      <= 14'd0;
         mb     <= 11'd0;
         eq     <= 8'sd0;
         sign   <= 1'b0;
         result <= FP16_ZERO;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: if (in_valid) begin
               if (spec_hit) begin
                  result <= spec_val;
               end else begin
                  sign <= sq;
                  rem  <= {1'b0, ma_n};
                  mb   <= mb_n;
                  eq   <= eq_calc;
                  q    <= 14'd0;
                  cnt  <= DIV_LAST_IDX;
               end
            end
            DIV: begin
               if (rem >= {1'b0, mb}) begin
                  q   <= {q[12:0], 1'b1};
                  rem <= {rem_sub[10:0], 1'b0};
               end else begin
                  q   <= {q[12:0], 1'b0};
                  rem <= {rem[10:0], 1'b0};
               end
               cnt <= cnt - 4'd1;
            end
            ROUND:   result <= packed_res;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fp16_div.sv
// Directed bench for fp16_div: arithmetic, specials, range limits, back-pressure, reset abort.
// Latency: measured per op as cycles from accept to out_valid.
// Backpressure: exercised by holding out_ready low with a concurrent in_valid.
module tb_fp16_div;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] a, b;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] result;

   int tests = 0;
   int fails = 0;

   fp16_div dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Issue one op, wait (bounded) for out_valid, check result and latency
   task automatic run_op(input string tag, input logic [15:0] ta, input logic [15:0] tb,
                         input logic [15:0] exp_res, input int exp_lat);
      int lat;
      @(negedge clk);
      check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
      a = ta;
      b = tb;
      in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!out_valid && lat < 40);
      check({tag, "_res"}, 32'(result), 32'(exp_res));
      if (exp_lat > 0) check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
   endtask

   initial begin
      rst = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b1;
      a = 16'h0;
      b = 16'h0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("reset_in_ready",  32'(in_ready),  32'd1);
      check("reset_out_valid", 32'(out_valid), 32'd0);
      check("reset_result",    32'(result),    32'h0);

      // arithmetic
      run_op("one_div_one",   16'h3C00, 16'h3C00, 16'h3C00, 16);
      run_op("three_div_two", 16'h4200, 16'h4000, 16'h3E00, 16);
      run_op("one_third",     16'h3C00, 16'h4200, 16'h3555, 16);
      run_op("neg_two_half",  16'hC000, 16'h3800, 16'hC400, 16);

      // specials
      run_op("zero_zero", 16'h0000, 16'h0000, 16'h7E00, 1);
      run_op("inf_inf",   16'h7C00, 16'h7C00, 16'h7E00, 1);
      run_op("x_zero",    16'h3C00, 16'h0000, 16'h7C00, 1);
      run_op("x_inf",     16'hBC00, 16'h7C00, 16'h8000, 1);
      run_op("nan_x",     16'h7E01, 16'h3C00, 16'h7E00, 1);

      // range
      run_op("overflow",   16'h7BFF, 16'h1400, 16'h7C00, 16);
      run_op("denorm_out", 16'h0400, 16'h4000, 16'h0200, 16);
      run_op("denorm_in",  16'h0001, 16'h3C00, 16'h0001, 16);

      // back-pressure: hold result in DONE while a new request is offered
      @(negedge clk);
      out_ready = 1'b0;
      run_op("bp_op", 16'h4200, 16'h4000, 16'h3E00, 16);
      a = 16'h3C00;
      b = 16'h0000;
      in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("bp_result",    32'(result),    32'h3E00);
         check("bp_in_ready",  32'(in_ready),  32'd0);
         check("bp_out_valid", 32'(out_valid), 32'd1);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      check("bp_release_in_ready",  32'(in_ready),  32'd1);
      check("bp_release_out_valid", 32'(out_valid), 32'd0);
      check("bp_release_result",    32'(result),    32'h3E00);

      // reset in the 7th DIV cycle discards the op
      @(negedge clk);
      a = 16'h4200;
      b = 16'h4000;
      in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (6) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("abort_out_valid", 32'(out_valid), 32'd0);
      check("abort_result",    32'(result),    32'h0);
      check("abort_in_ready",  32'(in_ready),  32'd1);
      rst = 1'b0;
      run_op("after_abort", 16'h3C00, 16'h3C00, 16'h3C00, 16);

      @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
